inport_in_interface_position_counter: RTL and testbench

//  Multi-channel phit-position counter for the inport input interface.
//  One position counter per virtual channel tracks where the interface is

---
 rtl/inport_if_pkg.sv | 14 +
 rtl/inport_in_interface_pos_cnt_slice.sv | 45 ++++
 rtl/inport_in_interface_position_counter.sv | 72 +++++++
 tb/tb_inport_in_interface_position_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/inport_if_pkg.sv
// inport_if_pkg: shared width helper and command priority encoding for the inport position counters
package inport_if_pkg;
  typedef enum logic [2:0] {CMD_HOLD, CMD_CLR, CMD_END, CMD_FIRST, CMD_INC, CMD_DEC} cmd_e;
  function automatic int bits_for(input int v);
    bits_for = 31;
    for (int i = 30; i >= 0; i--) if ((1 << i) > v) bits_for = i;
  endfunction
  function automatic bit widths_ok(input int flit_size, cnt_w, num_vc, vc_w);
    return num_vc >= 1 && flit_size >= 0 && cnt_w >= bits_for(flit_size) && vc_w >= 1 && vc_w >= bits_for(num_vc - 1);
  endfunction
  function automatic cmd_e cmd_sel(input logic clr, ld_end, ld_first, inc, dec);
    return clr ? CMD_CLR : ld_end ? CMD_END : ld_first ? CMD_FIRST : (inc && !dec) ? CMD_INC : (dec && !inc) ? CMD_DEC : CMD_HOLD;
  endfunction
endpackage

// File: rtl/inport_in_interface_pos_cnt_slice.sv
// inport_in_interface_pos_cnt_slice: one channel position counter with priority, wrap/saturate and over/underflow detect
// Optional INPORT_POS_CNT_ERR_FLAG_EN adds the ovf output.
module inport_in_interface_pos_cnt_slice
  import inport_if_pkg::*;
#(
  parameter int flit_size = 8,
  parameter int CNT_W     = 4,
  parameter int wrap_en   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             clr,
  input  logic             ld_end,
  input  logic             ld_first,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
  ,output logic            ovf
`endif
);
  localparam logic [CNT_W-1:0] FS = CNT_W'(flit_size);
  cmd_e cmd;
  logic at_end, at_first;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cmd      = cmd_sel(clr, sel & ld_end, sel & ld_first, sel & inc, sel & dec);
  assign at_end   = cnt_q == FS;
  assign at_first = cnt_q == '0;
  assign cnt      = cnt_q;
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
  assign ovf = (cmd == CMD_INC && at_end) || (cmd == CMD_DEC && at_first);
`endif
  // next count: loads first, then step with wrap or saturate at the ends
  always_comb
    cnt_d = (cmd == CMD_CLR || cmd == CMD_FIRST) ? '0 :
            cmd == CMD_END ? FS :
            cmd == CMD_INC ? (at_end ? (wrap_en != 0 ? '0 : FS) : cnt_q + 1'b1) :
            cmd == CMD_DEC ? (at_first ? (wrap_en != 0 ? FS : '0) : cnt_q - 1'b1) :
            cnt_q;
  // position register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/inport_in_interface_position_counter.sv
// inport_in_interface_position_counter: per-VC phit-position counters with vc_sel decode and combinational read mux
// Optional INPORT_POS_CNT_ERR_FLAG_EN adds a sticky err_flag on over/underflow.
module inport_in_interface_position_counter
  import inport_if_pkg::*;
#(
  parameter int flit_size                   = 8,
  parameter int floorplusone_log2_flit_size = 4,
  parameter int num_vc                      = 4,
  parameter int log2_num_vc                 = 2,
  parameter int wrap_en                     = 0
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [log2_num_vc-1:0]                         vc_sel,
  input  logic                                           inc,
  input  logic                                           dec,
  input  logic                                           rs_to_end,
  input  logic                                           rs_to_first,
  input  logic                                           clr_all,
  output logic [floorplusone_log2_flit_size-1:0]         out,
  output logic                                           at_end,
  output logic                                           at_first,
  output logic [num_vc*floorplusone_log2_flit_size-1:0]  out_all
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
  ,output logic                                          err_flag
`endif
);
  localparam int CNT_W = floorplusone_log2_flit_size;
  localparam int VC_W  = log2_num_vc;
  localparam logic [CNT_W-1:0] FS = CNT_W'(flit_size);
  logic [num_vc-1:0] sel;
  logic [CNT_W-1:0] cnt [num_vc];
  logic vld;
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
  logic [num_vc-1:0] ovf;
  logic err_q, err_d;
`endif
  if (!widths_ok(flit_size, CNT_W, num_vc, VC_W)) begin : g_bad_widths
    $error("inport_in_interface_position_counter: counter or vc_sel width too small");
  end
  for (genvar i = 0; i < num_vc; i++) begin : g_vc
    assign sel[i] = vc_sel == VC_W'(i);
    assign out_all[i*CNT_W +: CNT_W] = cnt[i];
    inport_in_interface_pos_cnt_slice #(.flit_size(flit_size), .CNT_W(CNT_W), .wrap_en(wrap_en)) u_slice (
      .clk(clk), .rst_n(rst_n), .sel(sel[i]), .clr(clr_all), .ld_end(rs_to_end),
      .ld_first(rs_to_first), .inc(inc), .dec(dec), .cnt(cnt[i])
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
      , .ovf(ovf[i])
`endif
    );
  end
  // read mux: out-of-range vc_sel reads 0 with both flags low
  always_comb begin
    out = '0;
    vld = 1'b0;
    for (int i = 0; i < num_vc; i++) if (sel[i]) begin
      out = cnt[i];
      vld = 1'b1;
    end
  end
  assign at_end   = vld && out == FS;
  assign at_first = vld && out == '0;
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
  // sticky error; clr_all wins over a same-cycle set
  always_comb err_d = clr_all ? 1'b0 : err_q | (|ovf);
  // error register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign err_flag = err_q;
`endif
endmodule

// File: tb/tb_inport_in_interface_position_counter.sv
// tb_inport_in_interface_position_counter: saturate and wrap instances checked against an integer reference model
module tb_inport_in_interface_position_counter;
  localparam int FS = 8;
  logic clk = 1'b0;
  logic rst_n, inc, dec, rs_to_end, rs_to_first, clr_all;
  logic [2:0] vc_sel;
  logic [3:0] out_w [2];
  logic [15:0] all_w [2];
  logic [1:0] end_w, first_w;
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
  logic [1:0] err_w;
`endif
  int m [2][4];
  int me [2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar w = 0; w < 2; w++) begin : g_dut
    inport_in_interface_position_counter #(
      .flit_size(FS), .floorplusone_log2_flit_size(4), .num_vc(4), .log2_num_vc(3), .wrap_en(w)
    ) dut (
      .clk(clk), .rst_n(rst_n), .vc_sel(vc_sel), .inc(inc), .dec(dec), .rs_to_end(rs_to_end),
      .rs_to_first(rs_to_first), .clr_all(clr_all), .out(out_w[w]), .at_end(end_w[w]),
      .at_first(first_w[w]), .out_all(all_w[w])
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
      , .err_flag(err_w[w])
`endif
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) m[w][i] = 0;
      me[w] = 0;
    end
  endtask
  task automatic model_step();
    int c, t;
    if (clr_all) begin
      model_clear();
      return;
    end
    if (vc_sel >= 4) return;
    for (int w = 0; w < 2; w++) begin
      c = m[w][vc_sel];
      if (rs_to_end) c = FS;
      else if (rs_to_first) c = 0;
      else if (inc != dec) begin
        t = c + (inc ? 1 : -1);
        if (t > FS || t < 0) begin
          me[w] = 1;
          t = (w == 1) ? (t > FS ? 0 : FS) : (t > FS ? FS : 0);
        end
        c = t;
      end
      m[w][vc_sel] = c;
    end
  endtask
  task automatic check_all(input string tag);
    int e;
    bit v;
    logic [15:0] ea;
    v = vc_sel < 4;
    for (int w = 0; w < 2; w++) begin
      e = v ? m[w][vc_sel] : 0;
      for (int i = 0; i < 4; i++) ea[i*4 +: 4] = 4'(m[w][i]);
      chk($sformatf("%s w%0d out", tag, w), 32'(out_w[w]), 32'(e));
      chk($sformatf("%s w%0d at_end", tag, w), 32'(end_w[w]), 32'(v && e == FS));
      chk($sformatf("%s w%0d at_first", tag, w), 32'(first_w[w]), 32'(v && e == 0));
      chk($sformatf("%s w%0d out_all", tag, w), 32'(all_w[w]), 32'(ea));
`ifdef INPORT_POS_CNT_ERR_FLAG_EN
      chk($sformatf("%s w%0d err_flag", tag, w), 32'(err_w[w]), 32'(me[w]));
`endif
    end
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all(tag);
  endtask
  task automatic cmd(input string tag, input int vc, input bit c, e, f, i, d);
    vc_sel = 3'(vc);
    clr_all = c;
    rs_to_end = e;
    rs_to_first = f;
    inc = i;
    dec = d;
    tick(tag);
  endtask
  initial begin
    rst_n = 1'b0;
    {inc, dec, rs_to_end, rs_to_first, clr_all} = '0;
    vc_sel = '0;
    model_clear();
    #2;
    check_all("reset");
    tick("reset_hold");
    rst_n = 1'b1;
    tick("reset_release");
    for (int k = 0; k < 8; k++) cmd("t1_inc_vc1", 1, 0, 0, 0, 1, 0);
    cmd("t2_load_end", 2, 0, 1, 0, 0, 0);
    cmd("t2_inc_at_end", 2, 0, 0, 0, 1, 0);
    cmd("t2_load_first", 2, 0, 0, 1, 0, 0);
    cmd("t2_dec_at_first", 2, 0, 0, 0, 0, 1);
    cmd("t3_load_end", 3, 0, 1, 0, 0, 0);
    cmd("t3_inc_at_end", 3, 0, 0, 0, 1, 0);
    cmd("t3_dec", 3, 0, 0, 0, 0, 1);
    cmd("t4_prio_end", 0, 0, 1, 1, 1, 0);
    cmd("t4_load_first", 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cmd("t4_inc", 0, 0, 0, 0, 1, 0);
    cmd("t4_inc_dec_hold", 0, 0, 0, 0, 1, 1);
    cmd("t4_clr_prio", 0, 1, 1, 0, 0, 0);
    cmd("t5_prep", 2, 0, 0, 0, 1, 0);
    cmd("t5_out_of_range_inc", 5, 0, 0, 0, 1, 0);
    cmd("t5_out_of_range_dec", 7, 0, 0, 0, 0, 1);
    cmd("t6_first", 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) cmd("t6_inc", 1, 0, 0, 0, 1, 0);
    cmd("t6_end_vc2", 2, 0, 1, 0, 0, 0);
    cmd("t6_overflow", 2, 0, 0, 0, 1, 0);
    cmd("t6_idle", 1, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("t6_async_reset");
    rst_n = 1'b1;
    tick("t6_after_reset");
    for (int k = 0; k < 400; k++) begin
      vc_sel = 3'($urandom_range(0, 5));
      clr_all = ($urandom_range(0, 31) == 0);
      rs_to_end = ($urandom_range(0, 7) == 0);
      rs_to_first = ($urandom_range(0, 7) == 0);
      inc = $urandom_range(0, 1) == 1;
      dec = $urandom_range(0, 1) == 1;
      tick("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
